// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling of LSB-first frames,
// optional parity, one stop bit, and one-cycle valid/error strobes.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_TYPE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  par_err,
    output logic                  busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int HALF = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_HALF  = CW'(HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic          PAR_ODD   = 1'(PARITY_TYPE);
    localparam logic          HAS_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t                state, state_nxt;
    logic                  sync1, rx_s;
    logic [CW-1:0]         cyc_cnt, cyc_nxt;
    logic [BW-1:0]         bit_cnt, bit_nxt;
    logic [DATA_WIDTH-1:0] shreg, sh_nxt;
    logic                  par_bad, pbad_nxt;
    logic [DATA_WIDTH-1:0] pdata_nxt;
    logic                  dv_nxt, fe_nxt, pe_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            sync1      <= 1'b1;
            rx_s       <= 1'b1;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            par_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            sync1      <= rx_in;
            rx_s       <= sync1;
            cyc_cnt    <= cyc_nxt;
            bit_cnt    <= bit_nxt;
            shreg      <= sh_nxt;
            par_bad    <= pbad_nxt;
            p_data     <= pdata_nxt;
            data_valid <= dv_nxt;
            frame_err  <= fe_nxt;
            par_err    <= pe_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc_cnt;
        bit_nxt   = bit_cnt;
        sh_nxt    = shreg;
        pbad_nxt  = par_bad;
        pdata_nxt = p_data;
        dv_nxt    = 1'b0;
        fe_nxt    = 1'b0;
        pe_nxt    = 1'b0;

        case (state)
            IDLE: begin
                cyc_nxt  = '0;
                bit_nxt  = '0;
                pbad_nxt = 1'b0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                // A start bit must still be low at its midpoint, else it was a glitch.
                if (cyc_cnt == CYC_HALF) begin
                    cyc_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    cyc_nxt = cyc_cnt + 1'b1;
                end
            end
            DATA: begin
                if (cyc_cnt == CYC_LAST) begin
                    cyc_nxt = '0;
                    sh_nxt  = {rx_s, shreg[DATA_WIDTH-1:1]};
                    bit_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) state_nxt = HAS_PAR ? PARITY : STOP;
                end else begin
                    cyc_nxt = cyc_cnt + 1'b1;
                end
            end
            PARITY: begin
                if (cyc_cnt == CYC_LAST) begin
                    cyc_nxt   = '0;
                    pbad_nxt  = rx_s ^ (^shreg) ^ PAR_ODD;
                    state_nxt = STOP;
                end else begin
                    cyc_nxt = cyc_cnt + 1'b1;
                end
            end
            STOP: begin
                // Leaving at mid-stop gives half a bit of margin for the next start edge.
                if (cyc_cnt == CYC_LAST) begin
                    cyc_nxt = '0;
                    if (rx_s) begin
                        state_nxt = IDLE;
                        if (par_bad) begin
                            pe_nxt = 1'b1;
                        end else begin
                            pdata_nxt = shreg;
                            dv_nxt    = 1'b1;
                        end
                    end else begin
                        fe_nxt    = 1'b1;
                        state_nxt = BREAK;
                    end
                end else begin
                    cyc_nxt = cyc_cnt + 1'b1;
                end
            end
            BREAK: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
